debounce_scan_ctrl: RTL and testbench

Time-multiplexed debounce controller for all front-panel inputs, i.e. the encoder A/B lines and push buttons feeding the RGB mixer.
- One shared sample/compare engine is scheduled round-robin over N_CH channels.
- Scans are paced by an internal sample-rate prescaler.
- Outputs are a stable level per channel plus single-cycle edge pulses for the encoder and PWM configuration logic.
- Replaces N_CH free-running per-input shift-register debouncers with a single sequenced datapath.

---
 rtl/debounce_scan_ctrl_if.sv | 28 ++
 rtl/debounce_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_debounce_scan_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/debounce_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : debounce_scan_ctrl_if
// Brief    : Raw inputs and debounced level/edge/status bundle for the scanner.
// Revision : 1.0
// ============================================================================
interface debounce_scan_ctrl_if #(
   parameter int N_CH = 6
);
   logic [N_CH-1:0] raw;
   logic            enable;
   logic [N_CH-1:0] debounced;
   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] fall;
   logic            scan_busy;
   logic            scan_done;

   modport master (
      output raw, enable,
      input  debounced, rise, fall, scan_busy, scan_done
   );

   modport slave (
      input  raw, enable,
      output debounced, rise, fall, scan_busy, scan_done
   );
endinterface
`default_nettype wire

// File: rtl/debounce_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : debounce_scan_ctrl
// Brief    : Round-robin debouncer sharing one compare engine over N_CH inputs.
// Revision : 1.0
// ============================================================================
module debounce_scan_ctrl #(
   parameter int N_CH       = 6,
   parameter int TICK_DIV   = 1000,
   parameter int STABLE_CNT = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   debounce_scan_ctrl_if.slave  bus
);
   localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int PW  = $clog2(TICK_DIV);
   localparam int CW  = $clog2(STABLE_CNT + 1);

   localparam logic [CHW-1:0] c_last_ch    = CHW'(N_CH - 1);
   localparam logic [PW-1:0]  c_presc_last = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0]  c_cnt_last   = CW'(STABLE_CNT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          r_state;
   logic [N_CH-1:0] r_sync1;
   logic [N_CH-1:0] r_sync2;
   logic [PW-1:0]   r_presc;
   logic [CHW-1:0]  r_ch;
   logic            r_pending;
   logic [CW-1:0]   r_cnt [N_CH];
   logic [N_CH-1:0] r_debounced;
   logic [N_CH-1:0] r_rise;
   logic [N_CH-1:0] r_fall;
   logic            r_busy;
   logic            r_done;

   logic w_tick;
   logic w_s;

   assign w_tick = bus.enable && (r_presc == c_presc_last);
   assign w_s    = r_sync2[r_ch];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_sync1     <= '0;
         r_sync2     <= '0;
         r_presc     <= '0;
         r_ch        <= '0;
         r_pending   <= 1'b0;
         r_debounced <= '0;
         r_rise      <= '0;
         r_fall      <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_sync1 <= bus.raw;
         r_sync2 <= r_sync1;
         r_rise  <= '0;
         r_fall  <= '0;

         if (!bus.enable || w_tick) begin
            r_presc <= '0;
         end else begin
            r_presc <= r_presc + 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_tick || r_pending) begin
                  r_state   <= ST_SCAN;
                  r_ch      <= '0;
                  r_pending <= 1'b0;
                  r_busy    <= 1'b1;
               end
            end
            ST_SCAN: begin
               // A sample that agrees with the current level restarts qualification.
               if (w_s == r_debounced[r_ch]) begin
                  r_cnt[r_ch] <= '0;
               end else if (r_cnt[r_ch] == c_cnt_last) begin
                  r_debounced[r_ch] <= w_s;
                  r_cnt[r_ch]       <= '0;
                  if (w_s) begin
                     r_rise[r_ch] <= 1'b1;
                  end else begin
                     r_fall[r_ch] <= 1'b1;
                  end
               end else begin
                  r_cnt[r_ch] <= r_cnt[r_ch] + 1'b1;
               end

               if (r_ch == c_last_ch) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_ch <= r_ch + 1'b1;
               end
               if (w_tick) begin
                  r_pending <= 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               if (w_tick) begin
                  r_pending <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase

         if (!bus.enable) begin
            r_pending <= 1'b0;
         end
      end
   end

   assign bus.debounced = r_debounced;
   assign bus.rise      = r_rise;
   assign bus.fall      = r_fall;
   assign bus.scan_busy = r_busy;
   assign bus.scan_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_debounce_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounce_scan_ctrl
// Brief    : Directed + random stimulus against a cycle-indexed scan model.
// Revision : 1.0
// ============================================================================
module tb_debounce_scan_ctrl;
   localparam int N  = 4;
   localparam int TD = 16;
   localparam int SC = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   debounce_scan_ctrl_if #(.N_CH(N)) bus ();

   debounce_scan_ctrl #(
      .N_CH       (N),
      .TICK_DIV   (TD),
      .STABLE_CNT (SC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic         rst_v = 1'b1;
   logic         en_v  = 1'b0;
   logic [N-1:0] raw_v = '0;

   // Model: scans are tracked by the cycle in which channel 0 is processed.
   int           presc      = 0;
   int           scan_start = -1;
   bit           pend       = 1'b0;
   int           m_cnt [N];
   logic [N-1:0] m_deb  = '0;
   logic [N-1:0] m_rise = '0;
   logic [N-1:0] m_fall = '0;
   logic [N-1:0] rawm1  = '0;
   logic [N-1:0] rawm2  = '0;
   logic         m_busy = 1'b0;
   logic         m_done = 1'b0;
   int           rise_seen [N];
   int           fall_seen [N];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_step();
      int pos;
      bit idle;
      bit tick;
      m_rise = '0;
      m_fall = '0;
      if (rst_v) begin
         presc      = 0;
         pend       = 1'b0;
         scan_start = -1;
         m_deb      = '0;
         rawm1      = '0;
         rawm2      = '0;
         foreach (m_cnt[i]) m_cnt[i] = 0;
      end else begin
         pos  = (scan_start >= 0) ? cyc - scan_start : -1;
         idle = (scan_start < 0);
         tick = en_v && (presc == TD - 1);
         if (pos >= 0 && pos < N) begin
            if (rawm2[pos] == m_deb[pos]) begin
               m_cnt[pos] = 0;
            end else if (m_cnt[pos] + 1 == SC) begin
               m_deb[pos] = rawm2[pos];
               m_cnt[pos] = 0;
               if (rawm2[pos]) m_rise[pos] = 1'b1;
               else            m_fall[pos] = 1'b1;
            end else begin
               m_cnt[pos]++;
            end
         end
         if (pos == N) scan_start = -1;
         if (idle && (tick || pend)) begin
            scan_start = cyc + 1;
            pend       = 1'b0;
         end else if (tick) begin
            pend = 1'b1;
         end
         if (!en_v) pend = 1'b0;
         presc = (!en_v || presc == TD - 1) ? 0 : presc + 1;
         rawm2 = rawm1;
         rawm1 = raw_v;
      end
      m_busy = (scan_start >= 0);
      m_done = (scan_start >= 0) && (cyc + 1 - scan_start == N);
   endtask

   task automatic step();
      @(negedge clk);
      reset      = rst_v;
      bus.raw    = raw_v;
      bus.enable = en_v;
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      chk("debounced", bus.debounced, m_deb);
      chk("rise", bus.rise, m_rise);
      chk("fall", bus.fall, m_fall);
      chk("scan_busy", bus.scan_busy, m_busy);
      chk("scan_done", bus.scan_done, m_done);
      chk("one_pulse", ($countones(bus.rise | bus.fall) <= 1), 1);
      for (int k = 0; k < N; k++) begin
         if (bus.rise[k] === 1'b1) rise_seen[k]++;
         if (bus.fall[k] === 1'b1) fall_seen[k]++;
      end
   endtask

   task automatic run_scans(input int k);
      int d = 0;
      for (int i = 0; i < k * (TD + N + 2) * 2 && d < k; i++) begin
         step();
         if (m_done) d++;
      end
   endtask

   task automatic clear_seen();
      foreach (rise_seen[i]) begin
         rise_seen[i] = 0;
         fall_seen[i] = 0;
      end
   endtask

   initial begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      clear_seen();

      // Reset defaults
      rst_v = 1'b1; en_v = 1'b1; raw_v = 4'hF;
      repeat (3) step();
      chk("reset_debounced", bus.debounced, 4'h0);
      chk("reset_busy", bus.scan_busy, 1'b0);
      rst_v = 1'b0; raw_v = 4'h0;
      run_scans(2);

      // Clean press on channel 2
      clear_seen();
      raw_v[2] = 1'b1;
      run_scans(6);
      chk("press_rise2", rise_seen[2], 1);
      chk("press_deb2", bus.debounced[2], 1'b1);
      chk("press_quiet", rise_seen[0] + rise_seen[1] + rise_seen[3], 0);

      // Bounce rejection on channel 1, run lengths below the qualification count
      clear_seen();
      for (int r = 0; r < 4; r++) begin
         raw_v[1] = 1'b1;
         run_scans($urandom_range(1, SC - 1));
         raw_v[1] = 1'b0;
         run_scans(1);
      end
      chk("bounce_no_rise1", rise_seen[1], 0);
      raw_v[1] = 1'b1;
      run_scans(6);
      chk("bounce_rise1", rise_seen[1], 1);

      // Release channel 2
      clear_seen();
      raw_v[2] = 1'b0;
      run_scans(6);
      chk("release_fall2", fall_seen[2], 1);
      chk("release_deb2", bus.debounced[2], 1'b0);

      // Enable dropped mid-scan, then reset at the channel-1 cycle
      for (int i = 0; i < 4 * TD && !m_busy; i++) step();
      en_v = 1'b0;
      for (int i = 0; i < 2 * N && !m_done; i++) step();
      chk("gate_done", bus.scan_done, 1'b1);
      repeat (3 * TD) step();
      en_v = 1'b1;
      for (int i = 0; i < 4 * TD && !(m_busy && cyc - scan_start == 1); i++) step();
      chk("at_ch1", bus.scan_busy, 1'b1);
      rst_v = 1'b1;
      step();
      rst_v = 1'b0;
      repeat (N + 2) step();

      // Simultaneous channels
      clear_seen();
      raw_v = 4'b1011;
      run_scans(6);
      chk("simul_rise0", rise_seen[0], 1);
      chk("simul_rise1", rise_seen[1], 1);
      chk("simul_rise3", rise_seen[3], 1);
      chk("simul_rise2", rise_seen[2], 0);

      // Random bouncing levels with occasional enable gaps
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 11) == 0) raw_v[$urandom_range(0, N - 1)] ^= 1'b1;
         if ($urandom_range(0, 299) == 0) en_v = ~en_v;
         if (i == 1499) en_v = 1'b1;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
